// File: rtl/uart_transmitter.sv
// uart_transmitter: 16x-oversampled UART transmit shifter with run-time frame format and valid/ready input
module uart_transmitter (
    input  logic       clk_16bd,
    input  logic       rst,
    input  logic [8:0] frame,
    input  logic       frame_valid,
    input  logic       parity,
    input  logic       parity_type,
    input  logic       stop_bits,
    input  logic [3:0] frame_length,
    output logic       frame_ready,
    output logic       Tx,
    output logic       tx_done
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    logic [2:0] state;
    logic [3:0] tick, idx, len, len_c;
    logic [8:0] data;
    logic       stop_cnt, par_en, par_bit, two_stop, par_calc, last;
    always_comb begin
        len_c    = frame_length < 4'd5 ? 4'd5 : frame_length > 4'd9 ? 4'd9 : frame_length;
        par_calc = ^(frame & (9'h1FF >> (4'd9 - len_c))) ^ parity_type;
        last     = tick == 4'd15;
    end
    always_ff @(posedge clk_16bd or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick        <= 4'd0;
            idx         <= 4'd0;
            len         <= 4'd0;
            data        <= 9'd0;
            stop_cnt    <= 1'b0;
            par_en      <= 1'b0;
            par_bit     <= 1'b0;
            two_stop    <= 1'b0;
            frame_ready <= 1'b1;
            Tx          <= 1'b1;
            tx_done     <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tick    <= state == IDLE ? 4'd0 : tick + 4'd1;
            case (state)
                IDLE: if (frame_valid) begin
                    state       <= START;
                    Tx          <= 1'b0;
                    frame_ready <= 1'b0;
                    data        <= frame;
                    len         <= len_c;
                    par_en      <= parity;
                    par_bit     <= par_calc;
                    two_stop    <= stop_bits;
                end
                START: if (last) begin
                    state <= DATA;
                    idx   <= 4'd0;
                    Tx    <= data[0];
                end
                DATA: if (last) begin
                    if (idx == len - 4'd1) begin
                        state    <= par_en ? PARITY : STOP;
                        Tx       <= par_en ? par_bit : 1'b1;
                        stop_cnt <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                        Tx  <= data[idx + 4'd1];
                    end
                end
                PARITY: if (last) begin
                    state    <= STOP;
                    Tx       <= 1'b1;
                    stop_cnt <= 1'b0;
                end
                STOP: if (last) begin
                    if (stop_cnt == two_stop) begin
                        state       <= IDLE;
                        tx_done     <= 1'b1;
                        frame_ready <= 1'b1;
                    end else begin
                        stop_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: directed frame vectors checked bit by bit at mid-bit, with timing and reset checks
module tb_uart_transmitter;
    logic       clk_16bd = 1'b0, rst = 1'b0, frame_valid = 1'b0;
    logic       parity = 1'b0, parity_type = 1'b0, stop_bits = 1'b0;
    logic [8:0] frame = 9'd0;
    logic [3:0] frame_length = 4'd8;
    logic       frame_ready, Tx, tx_done;
    int         cyc = 0, errors = 0, checks = 0;
    int         a, b, r, pulses, lows;

    uart_transmitter dut (
        .clk_16bd(clk_16bd), .rst(rst), .frame(frame), .frame_valid(frame_valid),
        .parity(parity), .parity_type(parity_type), .stop_bits(stop_bits),
        .frame_length(frame_length), .frame_ready(frame_ready), .Tx(Tx), .tx_done(tx_done)
    );

    always #5 clk_16bd = ~clk_16bd;
    always @(posedge clk_16bd) cyc++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic setup(input logic [8:0] f, input logic [3:0] l, input logic p, input logic pt, input logic sb);
        frame = f; frame_length = l; parity = p; parity_type = pt; stop_bits = sb;
        frame_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag, output int acc);
        acc = -1;
        for (int i = 0; i < 400; i++) begin
            if (frame_ready === 1'b1 && frame_valid) begin
                @(posedge clk_16bd);
                @(negedge clk_16bd);
                acc = cyc;
                break;
            end
            @(negedge clk_16bd);
        end
        chk({tag, " accepted"}, acc >= 0, 1);
        chk({tag, " start bit latency"}, Tx, 0);
        chk({tag, " ready drops"}, frame_ready, 0);
    endtask

    // seq holds the expected line bits in transmission order, first bit leftmost
    task automatic check_frame(input string tag, input int acc, input logic [15:0] seq, input int n, input int dur);
        for (int k = 0; k < n; k++) begin
            while (cyc < acc + 16 * k + 8) @(negedge clk_16bd);
            chk($sformatf("%s bit%0d", tag, k), Tx, seq[n - 1 - k]);
        end
        while (tx_done !== 1'b1 && cyc < acc + dur + 32) @(negedge clk_16bd);
        chk({tag, " duration"}, cyc - acc, dur);
        chk({tag, " ready at done"}, frame_ready, 1);
        chk({tag, " idle line"}, Tx, 1);
    endtask

    initial begin
        setup(9'h065, 4'd8, 1'b1, 1'b0, 1'b0);
        #12;
        chk("reset Tx", Tx, 1);
        chk("reset ready", frame_ready, 1);
        chk("reset done", tx_done, 0);
        @(negedge clk_16bd);
        rst = 1'b1;
        r = cyc;
        wait_accept("f1", a);
        chk("release latency", a - r, 1);
        check_frame("f1", a, 16'(11'b0_10100110_0_1), 11, 176);
        frame = 9'h047;
        wait_accept("f2", b);
        chk("back-to-back gap", b - a, 177);
        frame_valid = 1'b0;
        check_frame("f2", b, 16'(11'b0_11100010_0_1), 11, 176);
        @(negedge clk_16bd);

        setup(9'h007, 4'd5, 1'b1, 1'b1, 1'b1);
        wait_accept("odd2", a);
        frame_valid = 1'b0;
        check_frame("odd2", a, 16'(9'b0_11100_0_11), 9, 144);
        @(negedge clk_16bd);

        setup(9'h1A5, 4'd9, 1'b0, 1'b0, 1'b0);
        wait_accept("nine", a);
        frame_valid = 1'b0;
        check_frame("nine", a, 16'(11'b0_101001011_1), 11, 176);
        @(negedge clk_16bd);

        setup(9'h1A5, 4'd15, 1'b0, 1'b0, 1'b0);
        wait_accept("len15", a);
        frame_valid = 1'b0;
        check_frame("len15", a, 16'(11'b0_101001011_1), 11, 176);
        @(negedge clk_16bd);

        setup(9'h007, 4'd2, 1'b0, 1'b0, 1'b0);
        wait_accept("len2", a);
        frame_valid = 1'b0;
        check_frame("len2", a, 16'(7'b0_11100_1), 7, 112);
        @(negedge clk_16bd);

        setup(9'h065, 4'd8, 1'b1, 1'b0, 1'b0);
        wait_accept("midchg", a);
        frame_valid = 1'b0;
        fork
            check_frame("midchg", a, 16'(11'b0_10100110_0_1), 11, 176);
            begin
                while (cyc < a + 40) @(negedge clk_16bd);
                frame = 9'h1FF; parity = 1'b0; frame_length = 4'd5; frame_valid = 1'b1;
                @(negedge clk_16bd);
                frame_valid = 1'b0;
            end
        join
        repeat (20) @(negedge clk_16bd);
        chk("no second frame Tx", Tx, 1);
        chk("no second frame ready", frame_ready, 1);

        setup(9'h000, 4'd8, 1'b0, 1'b0, 1'b0);
        wait_accept("abort", a);
        frame_valid = 1'b0;
        while (cyc < a + 40) @(negedge clk_16bd);
        chk("abort pre-reset Tx", Tx, 0);
        #2 rst = 1'b0;
        #1;
        chk("abort Tx async", Tx, 1);
        chk("abort ready async", frame_ready, 1);
        chk("abort done async", tx_done, 0);
        @(negedge clk_16bd);
        rst = 1'b1;
        pulses = 0;
        lows = 0;
        repeat (200) begin
            @(negedge clk_16bd);
            pulses += int'(tx_done);
            lows += int'(!Tx);
        end
        chk("abort no done", pulses, 0);
        chk("abort line high", lows, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
